// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus player.
//   stim_state_t : playback FSM encoding
//   DEF_POLY     : default 19-bit MISR feedback polynomial
//   DEF_IN_W     : default DUT data-input width
//   RST_BIT      : position of the DUT-reset bit in a packed vector (= IN_W)
//   rst_bit()    : same position for an arbitrary input width
package stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } stim_state_t;

  localparam logic [18:0] DEF_POLY = 19'h4_0027;
  localparam int          DEF_IN_W = 8;
  localparam int          RST_BIT  = DEF_IN_W;

  // A stored vector is {rst, in[in_w-1:0]}: the reset flag sits just above the data.
  function automatic int rst_bit(input int in_w);
    return in_w;
  endfunction

endpackage

// File: rtl/stim_misr.sv
// Multiple-input signature register compressing DUT outputs.
//   clk  : clock
//   rst  : synchronous active-high reset (signature -> 0)
//   clr  : synchronous clear, used at the start of each playback
//   en   : fold din into the signature this cycle
//   din  : DUT output word
//   sig  : current signature
module stim_misr
  import stim_pkg::*;
#(
  parameter int           W    = 19,
  parameter logic [W-1:0] POLY = W'(DEF_POLY)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] fb;
  assign fb = sig[W-1] ? POLY : '0;

  always_ff @(posedge clk) begin
    if (rst || clr) sig <= '0;
    else if (en)    sig <= (sig << 1) ^ fb ^ din;
  end

endmodule

// File: rtl/stim_player.sv
// Stimulus sequencer: stores a program of {rst, in} vectors written through
// a write port, then replays it to a DUT one vector per clock (one-shot or
// looping).  Optionally folds the DUT outputs into a MISR signature.
//
// Build option: define STIM_PLAYER_MISR_EN to include the signature MISR;
// otherwise signature is constant 0 and dut_out is ignored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en/addr/data   program load port (honoured only in IDLE/DONE)
//   start, stop       begin / abort playback (stop wins over start)
//   loop_en           wrap to entry 0 after the last vector
//   length            vectors to play (clamped to DEPTH, latched at start)
//   dut_out           DUT output, compressed while vectors are presented
//   dut_rst, dut_in   vector driven to the DUT (held in reset when not playing)
//   busy, done        PRIME/PLAY, DONE status
//   vec_idx           index of the vector currently on dut_*
//   signature         MISR value
module stim_player
  import stim_pkg::*;
#(
  parameter int               IN_W  = DEF_IN_W,
  parameter int               OUT_W = 19,
  parameter int               DEPTH = 1024,
  parameter int               AW    = $clog2(DEPTH),
  parameter logic [OUT_W-1:0] POLY  = OUT_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [IN_W:0]    wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [AW:0]      length,
  input  logic [OUT_W-1:0] dut_out,
  output logic             dut_rst,
  output logic [IN_W-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    vec_idx,
  output logic [OUT_W-1:0] signature
);

  localparam int          VW      = IN_W + 1;
  localparam int          RST_POS = rst_bit(IN_W);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [VW-1:0] mem [DEPTH];
  logic [VW-1:0] rd_q;

  stim_state_t   state_q, state_d;
  logic [AW:0]   len_q, len_eff, len_m1;
  logic [AW-1:0] rd_addr, rd_idx;
  // [0]: rd_q holds a vector of this run, [1]: dut_* carries a vector
  logic [1:0]    vld_pipe;
  logic          idle_like, can_start, enter_prime, reading;
  logic          rd_wrap, last_pres, present;

  assign len_eff   = (length > DEPTH_L) ? DEPTH_L : length;
  assign len_m1    = len_q - ONE_L;
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign can_start = start && !stop && (length != '0);
  assign reading   = (state_q == ST_PRIME) || (state_q == ST_PLAY);
  assign rd_wrap   = ({1'b0, rd_addr} == len_m1);
  assign last_pres = vld_pipe[1] && ({1'b0, vec_idx} == len_m1);

  assign busy = reading;
  assign done = (state_q == ST_DONE);

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE,
      ST_DONE:  if (can_start) state_d = ST_PRIME;
      ST_PRIME: state_d = stop ? ST_DONE : ST_PLAY;
      ST_PLAY:  if (stop || (last_pres && !loop_en)) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign enter_prime = idle_like && (state_d == ST_PRIME);
  // A vector moves from the read register onto the DUT pins only while
  // playback continues; leaving PLAY puts the DUT straight back in reset.
  assign present     = (state_q == ST_PLAY) && (state_d == ST_PLAY) && vld_pipe[0];

  // ---------------- vector memory ----------------
  // Writes are blocked during playback so the running program is stable.
  always_ff @(posedge clk) begin
    if (wr_en && idle_like) mem[wr_addr] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  // ---------------- playback datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rd_addr  <= '0;
      rd_idx   <= '0;
      vld_pipe <= '0;
      dut_rst  <= 1'b1;
      dut_in   <= '0;
      vec_idx  <= '0;
    end else begin
      state_q <= state_d;

      if (enter_prime) begin
        len_q   <= len_eff;
        rd_addr <= '0;
      end else if (reading) begin
        // Address runs modulo len_q so a looping run wraps without a bubble;
        // the extra read past the end of a one-shot run is simply discarded.
        rd_idx  <= rd_addr;
        rd_addr <= rd_wrap ? '0 : rd_addr + AW'(1);
      end

      if (state_d == ST_PLAY) vld_pipe <= {present, reading};
      else                    vld_pipe <= '0;

      if (present) begin
        dut_rst <= rd_q[RST_POS];
        dut_in  <= rd_q[IN_W-1:0];
        vec_idx <= rd_idx;
      end else begin
        dut_rst <= 1'b1;
        dut_in  <= '0;
        vec_idx <= '0;
      end
    end
  end

  // ---------------- signature ----------------
`ifdef STIM_PLAYER_MISR_EN
  logic sig_en;
  // One fold per presented vector: dut_out is sampled in the cycle the
  // vector is on the DUT pins.
  assign sig_en = (state_q == ST_PLAY) && vld_pipe[1];

  stim_misr #(
    .W    (OUT_W),
    .POLY (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (enter_prime),
    .en  (sig_en),
    .din (dut_out),
    .sig (signature)
  );
`else
  logic unused_dut_out;
  assign unused_dut_out = ^dut_out;
  assign signature      = '0;
`endif

endmodule

// File: tb/tb_stim_player.sv
// Directed bench for stim_player (DEPTH=16 to keep the full-depth run short).
module tb_stim_player;
  import stim_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = 19;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst, wr_en, start, stop, loop_en;
  logic [AW-1:0]    wr_addr;
  logic [IN_W:0]    wr_data;
  logic [AW:0]      length;
  logic [OUT_W-1:0] dut_out;
  logic             dut_rst, busy, done;
  logic [IN_W-1:0]  dut_in;
  logic [AW-1:0]    vec_idx;
  logic [OUT_W-1:0] signature;

  int errors = 0;
  int checks = 0;

  stim_player #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .length(length),
    .dut_out(dut_out), .dut_rst(dut_rst), .dut_in(dut_in), .busy(busy),
    .done(done), .vec_idx(vec_idx), .signature(signature)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic [IN_W-1:0] din;
    logic           busy;
    logic           done;
    logic [AW-1:0]  idx;
  } exp_t;

  exp_t os[7];
  logic [IN_W:0] prog[4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input exp_t e);
    chk({nm, ".dut_rst"}, 32'(dut_rst), 32'(e.rst));
    chk({nm, ".dut_in"},  32'(dut_in),  32'(e.din));
    chk({nm, ".busy"},    32'(busy),    32'(e.busy));
    chk({nm, ".done"},    32'(done),    32'(e.done));
    chk({nm, ".vec_idx"}, 32'(vec_idx), 32'(e.idx));
  endtask

  task automatic chk_sig(input string nm, input logic [OUT_W-1:0] misr_val);
`ifdef STIM_PLAYER_MISR_EN
    chk(nm, 32'(signature), 32'(misr_val));
`else
    chk(nm, 32'(signature), 32'(misr_val & '0));
`endif
  endtask

  task automatic write(input int a, input logic [IN_W:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();          // edge T
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk({nm, ".done_in_time"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [IN_W-1:0] cap_din;
    logic [AW-1:0]   cap_idx;
    int n;

    prog = '{9'h100, 9'h0A5, 9'h05A, 9'h0FF};
    //        rst   din    busy  done  idx
    os[0] = '{1'b1, 8'h00, 1'b1, 1'b0, 4'd0};   // PRIME
    os[1] = '{1'b1, 8'h00, 1'b1, 1'b0, 4'd0};   // first PLAY cycle, read pending
    os[2] = '{1'b1, 8'h00, 1'b1, 1'b0, 4'd0};   // vector 0 = 9'h100
    os[3] = '{1'b0, 8'hA5, 1'b1, 1'b0, 4'd1};
    os[4] = '{1'b0, 8'h5A, 1'b1, 1'b0, 4'd2};
    os[5] = '{1'b0, 8'hFF, 1'b1, 1'b0, 4'd3};
    os[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 4'd0};   // DONE, DUT back in reset

    rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; stop = 0;
    loop_en = 0; length = '0; dut_out = 19'h00001;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk_vec("reset", '{1'b1, 8'h00, 1'b0, 1'b0, 4'd0});
    chk_sig("reset.sig", 19'h0);

    for (int i = 0; i < 4; i++) write(i, prog[i]);

    // one-shot, length 4
    length = 5'd4; loop_en = 1'b0;
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      chk_vec($sformatf("oneshot[%0d]", k), os[k]);
    end
    chk_sig("oneshot.sig", 19'h0000F);
    tick(); tick(); tick();
    chk("done_held", 32'(done), 32'd1);
    chk_sig("sig_held", 19'h0000F);

    // loop mode, stop after the second pass
    loop_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      if (k < 2) e = '{1'b1, 8'h00, 1'b1, 1'b0, 4'd0};
      else begin
        e.rst  = prog[(k-2)%4][IN_W];
        e.din  = prog[(k-2)%4][IN_W-1:0];
        e.busy = 1'b1; e.done = 1'b0; e.idx = AW'((k-2)%4);
      end
      chk_vec($sformatf("loop[%0d]", k), e);
    end
    stop = 1'b1;
    tick();            // T+10
    stop = 1'b0;
    chk_vec("loop.stopped", '{1'b1, 8'h00, 1'b0, 1'b1, 4'd0});
    chk_sig("loop.sig", 19'h000FF);
    loop_en = 1'b0;

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop.busy", 32'(busy), 32'd0);
    chk("startstop.done", 32'(done), 32'd1);

    // zero length: start ignored, stays IDLE
    do_reset();
    length = '0;
    pulse_start();
    chk("len0.busy", 32'(busy), 32'd0);
    tick();
    chk("len0.busy2", 32'(busy), 32'd0);
    chk("len0.done", 32'(done), 32'd0);

    // length beyond DEPTH: exactly DEPTH vectors
    for (int i = 4; i < DEPTH; i++) write(i, {1'b0, 8'(8'h10 + i)});
    length = 5'(DEPTH + 5);
    pulse_start();
    n = 0; cap_din = '0; cap_idx = '0;
    while (!done && n < 100) begin
      tick(); n++;
      if (n == DEPTH + 1) begin cap_din = dut_in; cap_idx = vec_idx; end
    end
    chk("clamp.cycles", 32'(n), 32'(DEPTH + 2));
    chk("clamp.last_idx", 32'(cap_idx), 32'(DEPTH - 1));
    chk("clamp.last_din", 32'(cap_din), 32'(8'h10 + DEPTH - 1));
    chk_sig("clamp.sig", 19'h0FFFF);

    // writes during PLAY are dropped
    length = 5'd4;
    pulse_start();
    tick(); tick();
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 9'h0CC;
    tick(); tick();
    wr_en = 1'b0;
    wait_done("wrplay", 20);
    pulse_start();
    tick(); tick(); tick();
    chk("wrplay.replay_din", 32'(dut_in), 32'h0A5);
    chk("wrplay.replay_idx", 32'(vec_idx), 32'd1);
    wait_done("wrplay2", 20);

    // reset mid-playback
    pulse_start();
    tick(); tick(); tick();   // T+3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_vec("midrst", '{1'b1, 8'h00, 1'b0, 1'b0, 4'd0});
    chk_sig("midrst.sig", 19'h0);
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      chk_vec($sformatf("after_rst[%0d]", k), os[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
